// File: rtl/config_latch_bank_ctrl.sv
// Programming controller for a bank of configuration latches.
// Clears the array, then writes one row per din handshake with a
// word-line pulse framed by bit-line setup and hold cycles.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   start                begin a full programming pass (ignored while busy)
//   din_valid, din       row data offered by the source
//   din_ready            controller accepts din this cycle
//   cfg_reset            latch-array reset pin
//   wl, bl               one-hot word lines, bit-line data
//   busy, done           pass in progress, one-cycle completion pulse
module config_latch_bank_ctrl #(
   parameter int NUM_WL     = 4,
   parameter int NUM_BL     = 8,
   parameter int WL_PULSE   = 2,
   parameter int CLR_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              din_valid,
   input  logic [NUM_BL-1:0] din,
   output logic              din_ready,
   output logic              cfg_reset,
   output logic [NUM_WL-1:0] wl,
   output logic [NUM_BL-1:0] bl,
   output logic              busy,
   output logic              done
);

   localparam int ROW_W = (NUM_WL > 1) ? $clog2(NUM_WL) : 1;
   localparam int CNT_MAX = (WL_PULSE > CLR_CYCLES) ? WL_PULSE : CLR_CYCLES;
   localparam int CNT_W = $clog2(CNT_MAX + 1);

   localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(NUM_WL - 1);
   localparam logic [CNT_W-1:0] CLR_LAST   = CNT_W'(CLR_CYCLES);
   localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(WL_PULSE);

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      WAIT_DATA,
      SETUP,
      PULSE,
      HOLD,
      DONE
   } state_t;

   state_t           state;
   logic [ROW_W-1:0] row;
   logic [CNT_W-1:0] cnt;
   logic [NUM_WL-1:0] row_dec;

   always_comb begin
      row_dec = '0;
      for (int i = 0; i < NUM_WL; i++) begin
         if (row == ROW_W'(i)) row_dec[i] = 1'b1;
      end
   end

   // Outputs are assigned on the edge that enters each state, so every
   // output always reflects the current state with no decode glitches.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         row       <= '0;
         cnt       <= '0;
         din_ready <= 1'b0;
         cfg_reset <= 1'b0;
         wl        <= '0;
         bl        <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  state     <= CLEAR;
                  row       <= '0;
                  cnt       <= CNT_W'(1);
                  cfg_reset <= 1'b1;
                  busy      <= 1'b1;
               end
            end
            CLEAR: begin
               if (cnt == CLR_LAST) begin
                  state     <= WAIT_DATA;
                  cfg_reset <= 1'b0;
                  din_ready <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            WAIT_DATA: begin
               if (din_valid) begin
                  state     <= SETUP;
                  bl        <= din;
                  din_ready <= 1'b0;
               end
            end
            SETUP: begin
               state <= PULSE;
               wl    <= row_dec;
               cnt   <= CNT_W'(1);
            end
            PULSE: begin
               if (cnt == PULSE_LAST) begin
                  state <= HOLD;
                  wl    <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            HOLD: begin
               if (row == LAST_ROW) begin
                  state <= DONE;
                  done  <= 1'b1;
                  bl    <= '0;
               end else begin
                  state     <= WAIT_DATA;
                  row       <= row + 1'b1;
                  din_ready <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            default: begin
               state     <= IDLE;
               din_ready <= 1'b0;
               cfg_reset <= 1'b0;
               wl        <= '0;
               bl        <= '0;
               busy      <= 1'b0;
               done      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_config_latch_bank_ctrl.sv
// Directed bench for config_latch_bank_ctrl with a 4x8 latch model
// and per-cycle word-line / timing monitors.
module tb_config_latch_bank_ctrl;

   localparam int NWL = 4;
   localparam int NBL = 8;
   localparam int WLP = 2;
   localparam int CLR = 2;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           start = 1'b0;
   logic           din_valid = 1'b0;
   logic [NBL-1:0] din = '0;
   logic           din_ready;
   logic           cfg_reset;
   logic [NWL-1:0] wl;
   logic [NBL-1:0] bl;
   logic           busy;
   logic           done;

   int nvec = 0;
   int nerr = 0;
   int hs = 0;
   int clr_cnt = 0;
   logic [NBL-1:0] lat [NWL];

   always #5 clk = ~clk;

   config_latch_bank_ctrl #(
      .NUM_WL(NWL),
      .NUM_BL(NBL),
      .WL_PULSE(WLP),
      .CLR_CYCLES(CLR)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .din_valid(din_valid),
      .din(din),
      .din_ready(din_ready),
      .cfg_reset(cfg_reset),
      .wl(wl),
      .bl(bl),
      .busy(busy),
      .done(done)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // cycles elapsed since the last din handshake edge
   always @(posedge clk) begin
      if (reset) hs = 0;
      else if (din_valid && din_ready) hs = 1;
      else if (hs > 0 && hs < WLP + 3) hs++;
      else hs = 0;
   end

   always @(negedge clk) begin
      chk("wl_onehot", 32'($countones(wl) <= 1), 32'd1);
      chk("wl_vs_clr", 32'(!((|wl) && cfg_reset)), 32'd1);
      if (hs == 1)
         chk("t_setup", 32'({wl, din_ready}), 32'd0);
      else if (hs >= 2 && hs <= WLP + 1)
         chk("t_pulse", 32'(|wl), 32'd1);
      else if (hs == WLP + 2)
         chk("t_hold", 32'(|wl), 32'd0);
      else if (hs == WLP + 3)
         chk("t_next", 32'(din_ready | done), 32'd1);
      if (cfg_reset) begin
         clr_cnt++;
         for (int i = 0; i < NWL; i++) lat[i] = '0;
      end
      for (int i = 0; i < NWL; i++) begin
         if (wl[i]) lat[i] = bl;
      end
   end

   task automatic start_pass(input logic [NBL-1:0] first);
      clr_cnt = 0;
      din_valid = 1'b1;
      din = first;
      start = 1'b1;
      tick;
      start = 1'b0;
      chk("clr1", 32'(cfg_reset), 32'd1);
      chk("clr_busy", 32'(busy), 32'd1);
      chk("clr_wl", 32'(wl), 32'd0);
      chk("clr_rdy", 32'(din_ready), 32'd0);
      tick;
      chk("clr2", 32'(cfg_reset), 32'd1);
      tick;
      chk("clr_end", 32'(cfg_reset), 32'd0);
      chk("wait_rdy", 32'(din_ready), 32'd1);
   endtask

   // entered in a WAIT_DATA cycle with din=val and din_valid=1
   task automatic do_row(input logic [NBL-1:0] val, input int r,
                         input logic [NBL-1:0] nxt, input bit stall,
                         input bit poke);
      tick;
      chk("setup_bl", 32'(bl), 32'(val));
      chk("setup_wl", 32'(wl), 32'd0);
      chk("setup_rdy", 32'(din_ready), 32'd0);
      din = nxt;
      for (int k = 0; k < WLP; k++) begin
         tick;
         chk("pulse_wl", 32'(wl), 32'(1 << r));
         chk("pulse_bl", 32'(bl), 32'(val));
         if (poke) start = (k == 0);
      end
      tick;
      chk("hold_wl", 32'(wl), 32'd0);
      chk("hold_bl", 32'(bl), 32'(val));
      chk("hold_clr", 32'(cfg_reset), 32'd0);
      if (stall) din_valid = 1'b0;
      tick;
      if (r == NWL - 1) begin
         chk("done", 32'(done), 32'd1);
         chk("done_bl", 32'(bl), 32'd0);
         chk("done_busy", 32'(busy), 32'd1);
      end else begin
         chk("rdy", 32'(din_ready), 32'd1);
         chk("wait_wl", 32'(wl), 32'd0);
      end
   endtask

   task automatic end_pass(input logic [NBL-1:0] e0, input logic [NBL-1:0] e1,
                           input logic [NBL-1:0] e2, input logic [NBL-1:0] e3);
      tick;
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
      chk("clr_cycles", 32'(clr_cnt), 32'(CLR));
      chk("lat0", 32'(lat[0]), 32'(e0));
      chk("lat1", 32'(lat[1]), 32'(e1));
      chk("lat2", 32'(lat[2]), 32'(e2));
      chk("lat3", 32'(lat[3]), 32'(e3));
   endtask

   initial begin
      tick;
      tick;
      chk("rst_wl", 32'(wl), 32'd0);
      chk("rst_bl", 32'(bl), 32'd0);
      chk("rst_clr", 32'(cfg_reset), 32'd0);
      chk("rst_rdy", 32'(din_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      reset = 1'b0;
      tick;
      chk("idle_busy0", 32'(busy), 32'd0);

      // full pass, din_valid always high
      start_pass(8'hA5);
      do_row(8'hA5, 0, 8'h3C, 1'b0, 1'b0);
      do_row(8'h3C, 1, 8'hFF, 1'b0, 1'b0);
      do_row(8'hFF, 2, 8'h00, 1'b0, 1'b0);
      do_row(8'h00, 3, 8'h00, 1'b0, 1'b0);
      end_pass(8'hA5, 8'h3C, 8'hFF, 8'h00);

      // stall before row 1, start poked during row 2 pulse
      start_pass(8'hA5);
      do_row(8'hA5, 0, 8'h3C, 1'b1, 1'b0);
      chk("stall_bl", 32'(bl), 32'hA5);
      for (int k = 0; k < 4; k++) begin
         tick;
         chk("stall_rdy", 32'(din_ready), 32'd1);
         chk("stall_wl", 32'(wl), 32'd0);
         chk("stall_bl", 32'(bl), 32'hA5);
      end
      din_valid = 1'b1;
      do_row(8'h3C, 1, 8'hFF, 1'b0, 1'b0);
      do_row(8'hFF, 2, 8'h00, 1'b0, 1'b1);
      do_row(8'h00, 3, 8'h00, 1'b0, 1'b0);
      end_pass(8'hA5, 8'h3C, 8'hFF, 8'h00);

      // reset during row 1 pulse aborts, then a fresh pass
      start_pass(8'h11);
      do_row(8'h11, 0, 8'h22, 1'b0, 1'b0);
      tick;
      tick;
      chk("abort_wl_pre", 32'(wl), 32'b0010);
      reset = 1'b1;
      tick;
      reset = 1'b0;
      chk("abort_wl", 32'(wl), 32'd0);
      chk("abort_bl", 32'(bl), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_rdy", 32'(din_ready), 32'd0);
      chk("abort_lat0", 32'(lat[0]), 32'h11);
      start_pass(8'h33);
      do_row(8'h33, 0, 8'h44, 1'b0, 1'b0);
      do_row(8'h44, 1, 8'h55, 1'b0, 1'b0);
      do_row(8'h55, 2, 8'h66, 1'b0, 1'b0);
      do_row(8'h66, 3, 8'h00, 1'b0, 1'b0);
      end_pass(8'h33, 8'h44, 8'h55, 8'h66);

      // reset wins over a simultaneous start
      reset = 1'b1;
      start = 1'b1;
      tick;
      chk("rs_busy", 32'(busy), 32'd0);
      chk("rs_clr", 32'(cfg_reset), 32'd0);
      reset = 1'b0;
      start = 1'b0;
      tick;
      chk("rs_busy2", 32'(busy), 32'd0);
      chk("rs_clr2", 32'(cfg_reset), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
